// File: rtl/cpu_mem_bridge.sv
// Bridges one CPU byte/half/word load or store onto a 16-bit wait-stated memory bus.
// Words become two halfword transfers; load data is lane-selected and extended back to the CPU.
module cpu_mem_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [1:0]            cpu_size,
  input  logic                  cpu_signed,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_be,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, XFER_LO, XFER_HI, RESP} state_t;

  state_t                state;
  logic                  we_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [15:0]           whi_q;
  logic [15:0]           lo_q;
  logic [TW-1:0]         tcount;

  logic                  misaligned;
  logic                  ack;
  logic                  timeout_hit;
  logic [7:0]            lane;
  logic [31:0]           load_data;

  assign misaligned  = (cpu_size == 2'd3) ||
                       (cpu_size == 2'd1 && cpu_addr[0]) ||
                       (cpu_size == 2'd2 && cpu_addr[1:0] != 2'b00);
  assign ack         = mem_req && mem_ack;
  assign timeout_hit = (tcount == TW'(TIMEOUT_CYCLES - 1));
  assign lane        = addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];

  // Word results join the latched low half with the high half arriving now.
  always_comb begin
    load_data = {16'h0, mem_rdata};
    case (size_q)
      2'd0:    load_data = {{24{signed_q & lane[7]}}, lane};
      2'd1:    load_data = {{16{signed_q & mem_rdata[15]}}, mem_rdata};
      default: load_data = {mem_rdata, lo_q};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      addr_q    <= '0;
      whi_q     <= 16'h0;
      lo_q      <= 16'h0;
      tcount    <= '0;
      cpu_rdata <= 32'h0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 2'b00;
      mem_wdata <= 16'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            we_q     <= cpu_we;
            size_q   <= cpu_size;
            signed_q <= cpu_signed;
            addr_q   <= cpu_addr;
            whi_q    <= cpu_wdata[31:16];
            busy     <= 1'b1;
            tcount   <= '0;
            if (misaligned) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= XFER_LO;
              mem_req   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= {cpu_addr[ADDR_WIDTH-1:1], 1'b0};
              mem_be    <= (cpu_size == 2'd0) ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b11;
              mem_wdata <= (cpu_size == 2'd0) ? {2{cpu_wdata[7:0]}} : cpu_wdata[15:0];
            end
          end
        end
        XFER_LO, XFER_HI: begin
          if (ack) begin
            tcount <= '0;
            if (state == XFER_LO && size_q == 2'd2) begin
              state     <= XFER_HI;
              lo_q      <= mem_rdata;
              mem_addr  <= addr_q + ADDR_WIDTH'(2);
              mem_be    <= 2'b11;
              mem_wdata <= whi_q;
            end else begin
              state   <= RESP;
              mem_req <= 1'b0;
              done    <= 1'b1;
              err     <= 1'b0;
              if (!we_q) cpu_rdata <= load_data;
            end
          end else if (timeout_hit) begin
            // Abandon the access: the bus never answered.
            state     <= RESP;
            mem_req   <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            cpu_rdata <= 32'h0;
          end else begin
            tcount <= tcount + TW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
